// File: rtl/fp16_pkg.sv
// Shared constants, quotient width and FSM state encoding for the fp16 divider.
// FP16DIV_ROUND_EN widens the quotient by one guard bit for round-to-nearest-even.
package fp16_pkg;
    localparam int         EXP_BIAS  = 15;
    localparam logic [4:0] EXP_MAX   = 5'h1F;
    localparam logic [9:0] QNAN_MANT = 10'h3FF;
`ifdef FP16DIV_ROUND_EN
    localparam int         Q_BITS    = 13;
`else
    localparam int         Q_BITS    = 12;
`endif
    typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;
endpackage

// File: rtl/fp16_classify.sv
// Combinational fp16 operand classifier; denormals read as signed zero (DAZ).
module fp16_classify
    import fp16_pkg::*;
(
    input  logic [15:0] i_word,
    output logic        o_sign,
    output logic        o_is_zero,
    output logic        o_is_inf,
    output logic        o_is_nan,
    output logic        o_is_norm
);
    logic [4:0] w_exp;
    logic       w_mant_nz;

    assign w_exp     = i_word[14:10];
    assign w_mant_nz = |i_word[9:0];
    assign o_sign    = i_word[15];
    assign o_is_zero = (w_exp == 5'd0);
    assign o_is_inf  = (w_exp == EXP_MAX) && !w_mant_nz;
    assign o_is_nan  = (w_exp == EXP_MAX) && w_mant_nz;
    assign o_is_norm = (w_exp != 5'd0) && (w_exp != EXP_MAX);
endmodule

// File: rtl/fp16div.sv
// Multi-cycle fp16 divider: restoring division, one quotient bit per cycle, FTZ/DAZ.
// Default truncates (RTZ); define FP16DIV_ROUND_EN for round-to-nearest-even.
module fp16div
    import fp16_pkg::*;
#(
    parameter int EXP_BIAS = fp16_pkg::EXP_BIAS
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic        o_valid,
    output logic [15:0] o_res
);
    state_t              r_state;
    logic                r_ready;
    logic                r_valid;
    logic [15:0]         r_res;
    logic                r_sign;
    logic signed [6:0]   r_exp;
    logic [10:0]         r_bm;
    logic [12:0]         r_rem;
    logic [Q_BITS-1:0]   r_q;
    logic [3:0]          r_cnt;

    logic w_a_sign, w_a_zero, w_a_inf, w_a_nan, w_a_norm;
    logic w_b_sign, w_b_zero, w_b_inf, w_b_nan, w_b_norm;
    logic w_sign, w_special, w_spec_nan, w_spec_inf;
    logic [15:0]       w_spec_res;
    logic signed [6:0] w_exp_in;
    logic              w_ge;
    logic [12:0]       w_rem_sub;
    logic              w_hi;
    logic signed [6:0] w_exp_n;
    logic signed [6:0] w_exp_fin;
    logic [9:0]        w_mant;
    logic [9:0]        w_mant_fin;
    logic [15:0]       w_norm_res;
`ifdef FP16DIV_ROUND_EN
    logic              w_guard;
    logic              w_sticky;
    logic [10:0]       w_mant_rnd;
`endif

    fp16_classify u_cls_a (
        .i_word   (i_a),
        .o_sign   (w_a_sign),
        .o_is_zero(w_a_zero),
        .o_is_inf (w_a_inf),
        .o_is_nan (w_a_nan),
        .o_is_norm(w_a_norm)
    );

    fp16_classify u_cls_b (
        .i_word   (i_b),
        .o_sign   (w_b_sign),
        .o_is_zero(w_b_zero),
        .o_is_inf (w_b_inf),
        .o_is_nan (w_b_nan),
        .o_is_norm(w_b_norm)
    );

    // Priority: NaN-producing cases, then infinity, then zero.
    assign w_sign     = w_a_sign ^ w_b_sign;
    assign w_special  = !(w_a_norm && w_b_norm);
    assign w_spec_nan = w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf);
    assign w_spec_inf = w_a_inf || w_b_zero;
    assign w_spec_res = w_spec_nan ? {w_sign, EXP_MAX, QNAN_MANT} :
                        w_spec_inf ? {w_sign, EXP_MAX, 10'h000} :
                                     {w_sign, 15'h0000};
    assign w_exp_in   = $signed({2'b00, i_a[14:10]}) - $signed({2'b00, i_b[14:10]})
                      + $signed(7'(EXP_BIAS));

    assign w_ge      = (r_rem >= {2'b00, r_bm});
    assign w_rem_sub = w_ge ? (r_rem - {2'b00, r_bm}) : r_rem;

    always_comb begin
        w_hi    = r_q[Q_BITS-1];
        w_exp_n = w_hi ? r_exp : (r_exp - 7'sd1);
        w_mant  = w_hi ? r_q[Q_BITS-2:Q_BITS-11] : r_q[Q_BITS-3:Q_BITS-12];
`ifdef FP16DIV_ROUND_EN
        w_guard    = w_hi ? r_q[1] : r_q[0];
        w_sticky   = (w_hi && r_q[0]) || (|r_rem);
        w_mant_rnd = {1'b0, w_mant} + {10'd0, w_guard && (w_sticky || w_mant[0])};
        w_mant_fin = w_mant_rnd[9:0];
        w_exp_fin  = w_exp_n + $signed({6'd0, w_mant_rnd[10]});
`else
        w_mant_fin = w_mant;
        w_exp_fin  = w_exp_n;
`endif
        if (w_exp_fin >= 7'sd31) begin
            w_norm_res = {r_sign, EXP_MAX, 10'h000};
        end else if (w_exp_fin <= 7'sd0) begin
            w_norm_res = {r_sign, 15'h0000};
        end else begin
            w_norm_res = {r_sign, w_exp_fin[4:0], w_mant_fin};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_res   <= 16'h0000;
            r_sign  <= 1'b0;
            r_exp   <= '0;
            r_bm    <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_ready <= 1'b0;
                        r_sign  <= w_sign;
                        if (w_special) begin
                            r_res   <= w_spec_res;
                            r_valid <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_exp   <= w_exp_in;
                            r_rem   <= {2'b01, i_a[9:0], 1'b0} >> 1;
                            r_bm    <= {1'b1, i_b[9:0]};
                            r_q     <= '0;
                            r_cnt   <= '0;
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    // Partial remainder stays below 2*divisor, so the shift never overflows.
                    r_q   <= {r_q[Q_BITS-2:0], w_ge};
                    r_rem <= {w_rem_sub[11:0], 1'b0};
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'(Q_BITS - 1)) begin
                        r_state <= NORM;
                    end
                end
                NORM: begin
                    r_res   <= w_norm_res;
                    r_valid <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_res   = r_res;
endmodule

// File: tb/tb_fp16div.sv
// Randomized bench for fp16div against an arithmetic reference model of fp16 division.
module tb_fp16div;
`ifdef FP16DIV_ROUND_EN
    localparam int NLAT = 15;
    localparam bit RND  = 1'b1;
`else
    localparam int NLAT = 14;
    localparam bit RND  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld = 1'b0;
    logic [15:0] a   = 16'h0000;
    logic [15:0] b   = 16'h0000;
    logic        ready;
    logic        ovld;
    logic [15:0] res;

    fp16div #(.EXP_BIAS(15)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_valid(vld),
        .o_ready(ready),
        .i_a    (a),
        .i_b    (b),
        .o_valid(ovld),
        .o_res  (res)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reference: true quotient of the significands, truncated or rounded to 10 fraction bits.
    function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] y);
        int  ex, ey, mx, my, e, k, num, q, r;
        logic s;
        bit  zx, zy, ix, iy, nx, ny;
        s  = x[15] ^ y[15];
        ex = int'(x[14:10]);
        ey = int'(y[14:10]);
        mx = int'(x[9:0]);
        my = int'(y[9:0]);
        zx = (ex == 0);
        zy = (ey == 0);
        ix = (ex == 31) && (mx == 0);
        iy = (ey == 31) && (my == 0);
        nx = (ex == 31) && (mx != 0);
        ny = (ey == 31) && (my != 0);
        if (nx || ny || (zx && zy) || (ix && iy)) return {s, 15'h7FFF};
        if (ix || zy) return {s, 15'h7C00};
        if (zx || iy) return {s, 15'h0000};
        mx = mx + 1024;
        my = my + 1024;
        e  = ex - ey + 15;
        k  = 10;
        if (mx < my) begin
            e = e - 1;
            k = 11;
        end
        num = mx << k;
        q   = num / my;
        r   = num % my;
        if (RND) begin
            if ((2 * r > my) || ((2 * r == my) && (q % 2 == 1))) q = q + 1;
            if (q == 2048) begin
                q = 1024;
                e = e + 1;
            end
        end
        if (e >= 31) return {s, 15'h7C00};
        if (e <= 0) return {s, 15'h0000};
        return {s, 5'(e), 10'(q - 1024)};
    endfunction

    function automatic bit is_special(input logic [15:0] x, input logic [15:0] y);
        return (x[14:10] == 5'd0) || (x[14:10] == 5'd31) || (y[14:10] == 5'd0) || (y[14:10] == 5'd31);
    endfunction

    function automatic logic [15:0] rnd_op();
        logic [15:0] v;
        int t;
        v = 16'($urandom);
        t = $urandom_range(0, 11);
        if (t == 0)      v[14:10] = 5'd0;
        else if (t == 1) v[14:0]  = 15'h7C00;
        else if (t == 2) v[14:10] = 5'd31;
        else if (t == 3) v[14:10] = 5'($urandom_range(1, 3));
        else if (t == 4) v[14:10] = 5'($urandom_range(28, 30));
        else             v[14:10] = 5'($urandom_range(1, 30));
        return v;
    endfunction

    typedef struct {
        logic [15:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_cur;
    logic [15:0] held     = 16'h0000;
    bit          rst_seen = 1'b1;

    always @(negedge clk) begin
        if (rst_seen) begin
            check("rst_ready", 32'(ready), 32'd1);
            check("rst_valid", 32'(ovld), 32'd0);
            check("rst_res", 32'(res), 32'h0);
        end else begin
            check("ready", 32'(ready), 32'(sb.size() == 0));
            if (ovld) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", 32'(ovld), 32'd0);
                end else begin
                    e_cur = sb.pop_front();
                    check("res", 32'(res), 32'(e_cur.res));
                    check("latency", 32'(cyc - e_cur.acc + 1), 32'(e_cur.lat));
                    held = e_cur.res;
                end
            end else begin
                check("held", 32'(res), 32'(held));
                if (sb.size() > 0 && (cyc - sb[0].acc) > 40) begin
                    check("timeout", 32'(ovld), 32'd1);
                    void'(sb.pop_front());
                end
            end
        end
        rst_seen = rst;
        if (rst) begin
            sb.delete();
            held = 16'h0000;
        end else if (vld && ready) begin
            sb.push_back('{model(a, b), cyc + 1, is_special(a, b) ? 1 : NLAT});
        end
    end

    task automatic op(input logic [15:0] xa, input logic [15:0] xb,
                      input logic [15:0] want, input int wlat);
        int lat;
        bit got;
        check("model_pin", 32'(model(xa, xb)), 32'(want));
        @(posedge clk);
        #1 vld = 1'b1;
        a = xa;
        b = xb;
        @(negedge clk);
        for (int n = 0; n < 40 && !ready; n++) @(negedge clk);
        @(posedge clk);
        #1 vld = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        got = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (ovld) begin
                got = 1'b1;
                lat = n;
                break;
            end
        end
        if (!got) begin
            check("dir_timeout", 32'(ovld), 32'd1);
        end else begin
            check("dir_res", 32'(res), 32'(want));
            check("dir_lat", 32'(lat), 32'(wlat));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit got;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        op(16'h4600, 16'h4000, 16'h4200, NLAT);
        op(16'h3C00, 16'h3C00, 16'h3C00, NLAT);
        op(16'h3C00, 16'h3FFF, RND ? 16'h3801 : 16'h3800, NLAT);
        op(16'h7C00, 16'h7C00, 16'h7FFF, 1);
        op(16'hBC00, 16'h0000, 16'hFC00, 1);
        op(16'h3C00, 16'h0001, 16'h7C00, 1);
        op(16'h0000, 16'h3C00, 16'h0000, 1);
        op(16'h8000, 16'h3C00, 16'h8000, 1);
        op(16'h7E00, 16'h3C00, 16'h7FFF, 1);
        op(16'h7BFF, 16'h0400, 16'h7C00, NLAT);
        op(16'h0400, 16'h7BFF, 16'h0000, NLAT);

        // Abort a division during its fifth CALC cycle.
        @(posedge clk);
        #1 vld = 1'b1;
        a = 16'h4600;
        b = 16'h4000;
        @(negedge clk);
        for (int n = 0; n < 40 && !ready; n++) @(negedge clk);
        @(posedge clk);
        #1 vld = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_res", 32'(res), 32'h0);
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (ovld) got = 1'b1;
        end
        check("abort_no_valid", 32'(got), 32'd0);
        op(16'h4600, 16'h4000, 16'h4200, NLAT);

        // Valid held high with operands changing every cycle.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1 vld = 1'b1;
            a = rnd_op();
            b = rnd_op();
        end

        // Sporadic valid with rare resets.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1 vld = ($urandom_range(0, 3) == 0);
            a   = rnd_op();
            b   = rnd_op();
            rst = ($urandom_range(0, 199) == 0);
        end
        @(posedge clk);
        #1 vld = 1'b0;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
